// File: rtl/fxp_pkg.sv
// fxp_pkg: shared Q8.8 constants and divider state encoding
package fxp_pkg;
    localparam int WIDTH = 16;
    localparam int FRAC = 8;
    localparam logic [WIDTH-1:0] Q_MAX = 16'h7FFF;
    localparam logic [WIDTH-1:0] Q_MIN = 16'h8000;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring-division step
module fxp_div_step #(
    parameter int RW = 18,
    parameter int DW = 17
) (
    input  logic [RW-1:0] rem_in,
    input  logic          num_bit,
    input  logic [DW-1:0] dvs,
    output logic [RW-1:0] rem_out,
    output logic          q_bit
);
    logic [RW-1:0] shifted;
    logic [RW-1:0] diff;
    assign shifted = {rem_in[RW-2:0], num_bit};
    assign diff = shifted - {{(RW-DW){1'b0}}, dvs};
    // a bit shifted out of the top means the trial value certainly exceeds the divisor
    assign q_bit = ~diff[RW-1] | rem_in[RW-1];
    assign rem_out = q_bit ? diff : shifted;
endmodule

// File: rtl/fxp_div.sv
// fxp_div: sequential signed Q-format divider with truncation toward zero and saturation
module fxp_div
    import fxp_pkg::*;
#(
    parameter int WIDTH = fxp_pkg::WIDTH,
    parameter int FRAC = fxp_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             ovf,
    output logic             dbz
);
    localparam int N = WIDTH + FRAC;
    localparam int RW = WIDTH + 2;
    localparam int DW = WIDTH + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t state, next;
    logic [CW-1:0] cnt;
    logic [N-1:0] num;
    logic [DW-1:0] dvs;
    logic [RW-1:0] rem, rem_nxt;
    logic q_bit, neg, a_neg, dbz_f, fix_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, fix_q;

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign abs_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign abs_b = divisor[WIDTH-1] ? -divisor : divisor;

    fxp_div_step #(.RW(RW), .DW(DW)) u_step (
        .rem_in(rem),
        .num_bit(num[N-1]),
        .dvs(dvs),
        .rem_out(rem_nxt),
        .q_bit(q_bit)
    );

    // the negative side of the range holds one more magnitude than the positive side
    assign fix_ovf = !dbz_f && (neg ? num > {{FRAC{1'b0}}, SAT_MIN} : num > {{FRAC{1'b0}}, SAT_MAX});
    assign fix_q = dbz_f ? (a_neg ? SAT_MIN : SAT_MAX)
                 : fix_ovf ? (neg ? SAT_MIN : SAT_MAX)
                 : neg ? -num[WIDTH-1:0] : num[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (in_valid) next = CALC;
            CALC: if (cnt == CW'(N - 1)) next = FIX;
            FIX: next = DONE;
            DONE: if (out_ready) next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            num <= '0;
            dvs <= '0;
            rem <= '0;
            neg <= 1'b0;
            a_neg <= 1'b0;
            dbz_f <= 1'b0;
            quotient <= '0;
            ovf <= 1'b0;
            dbz <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    num <= {abs_a, {FRAC{1'b0}}};
                    dvs <= {1'b0, abs_b};
                    neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    a_neg <= dividend[WIDTH-1];
                    dbz_f <= divisor == '0;
                    rem <= '0;
                    cnt <= '0;
                end
                // the numerator register doubles as the quotient shift register
                CALC: begin
                    rem <= rem_nxt;
                    num <= {num[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    quotient <= fix_q;
                    ovf <= fix_ovf;
                    dbz <= dbz_f;
                end
                DONE: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fxp_div.sv
// tb_fxp_div: directed and random checks of fxp_div against an integer-arithmetic model
module tb_fxp_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [15:0] quotient;
    logic ovf;
    logic dbz;
    int tests = 0;
    int fails = 0;

    fxp_div dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
        .out_ready(out_ready), .quotient(quotient), .ovf(ovf), .dbz(dbz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic o, output logic d);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d = (sb == 0);
        o = 1'b0;
        if (d) q = (sa >= 0) ? 16'h7FFF : 16'h8000;
        else begin
            r = (sa * 256) / sb;
            if (r > 32767) begin q = 16'h7FFF; o = 1'b1; end
            else if (r < -32768) begin q = 16'h8000; o = 1'b1; end
            else q = r[15:0];
        end
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int hold);
        logic [15:0] eq;
        logic eo, ed;
        int w, lat;
        model(a, b, eq, eo, ed);
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        check("in_ready_before_accept", in_ready, 1);
        dividend = a;
        divisor = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        check("latency", lat, 25);
        check("quotient", quotient, eq);
        check("ovf", ovf, eo);
        check("dbz", dbz, ed);
        if (hold > 0) begin
            in_valid = 1'b1;
            dividend = 16'h1234;
            divisor = 16'h0100;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_quotient", quotient, eq);
                check("hold_in_ready", in_ready, 0);
                check("hold_out_valid", out_valid, 1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        check("in_ready_after_drop", in_ready, 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_quotient", quotient, 0);
        check("reset_ovf", ovf, 0);
        check("reset_dbz", dbz, 0);
        run_op(16'h0300, 16'h0200, 0);
        run_op(16'hFD00, 16'h0200, 0);
        run_op(16'h0100, 16'hFD00, 0);
        run_op(16'h7F00, 16'h0001, 0);
        run_op(16'h8000, 16'h0001, 0);
        run_op(16'h8000, 16'h0100, 0);
        run_op(16'hFD00, 16'h0000, 0);
        run_op(16'h0000, 16'h0000, 0);
        run_op(16'h0100, 16'h0300, 10);
        run_op(16'h0180, 16'hFF00, 0);
        dividend = 16'h0500;
        divisor = 16'h0300;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_valid", out_valid, 0);
        check("midreset_quotient", quotient, 0);
        run_op(16'h0500, 16'h0300, 0);
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? 16'($urandom_range(0, 1024)) : 16'($urandom);
            if (i % 7 == 0) rb = -rb;
            run_op(ra, rb, (i % 25 == 0) ? 2 : 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
